alu4_trace_recorder: RTL and testbench

- Hardware capture buffer for the 4-bit ALU datapath. Records each valid ALU transaction as a 15-bit word {a[3:0], b[3:0], op[2:0], result[3:0]}, the same layout the ALU self-checking bench loads from its vector file.
- Recorded traces are streamed back out over a valid/ready port, so silicon/FPGA runs can produce vector files for regression.
- Sits beside alu4, tapping its inputs and result.

---
 rtl/alu4_pkg.sv | 34 +++
 rtl/alu4_trace_ram.sv | 31 +++
 rtl/alu4_trace_recorder.sv | 175 +++++++++++++++++
 tb/tb_alu4_trace_recorder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared widths, opcodes and recorder state for the 4-bit ALU datapath.
package alu4_pkg;

    localparam int A_W   = 4;
    localparam int OP_W  = 3;
    localparam int RES_W = 4;
    localparam int REC_W = 2 * A_W + OP_W + RES_W;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DUMP    = 2'd2
    } state_t;

    // Record layout matches the ALU vector-file word: {a, b, op, result}.
    function automatic logic [REC_W-1:0] pack_record(
        input logic [A_W-1:0]   a,
        input logic [A_W-1:0]   b,
        input logic [OP_W-1:0]  op,
        input logic [RES_W-1:0] result
    );
        return {a, b, op, result};
    endfunction

endpackage

// File: rtl/alu4_trace_ram.sv
// Simple dual-port trace memory: synchronous write, registered read that
// holds its output while re is low so the read stage can stall.
module alu4_trace_ram
    import alu4_pkg::*;
#(
    parameter int DEPTH = 101,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [REC_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [REC_W-1:0] rdata
);

    localparam int MW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[MW-1:0]] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr[MW-1:0]];
        end
    end

endmodule

// File: rtl/alu4_trace_recorder.sv
// Capture buffer beside alu4: records valid transactions in arrival order and
// streams them back out over a valid/ready port on request.
module alu4_trace_recorder
    import alu4_pkg::*;
#(
    parameter int DEPTH = 101,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dump,
    input  logic             in_valid,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [OP_W-1:0]  op,
    input  logic [RES_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_data,
    output logic             out_last,
    output logic [AW-1:0]    count,
    output logic             full,
    output logic             overflow,
    output logic             busy,
    output state_t           state
);

    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

    state_t           state_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    count_next;
    logic [REC_W-1:0] ram_rdata;
    logic             s1_valid;
    logic             s1_last;
    logic             we;
    logic             re;
    logic             drop;
    logic             take;
    logic             advance;

    // Output handshake: a record transfers on any edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low,
    // out_data and out_last are held unchanged.
    assign take    = out_valid && out_ready;
    // Stage 1 is the RAM read register; it moves into the output register
    // whenever that register is empty or being drained this cycle.
    assign advance = s1_valid && (!out_valid || out_ready);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CAPTURE;
                end else if (dump && count != '0) begin
                    state_next = DUMP;
                end
            end
            CAPTURE: begin
                if (start) begin
                    state_next = CAPTURE;
                end else if (stop) begin
                    state_next = IDLE;
                end
            end
            DUMP: begin
                if (start) begin
                    state_next = CAPTURE;
                end else if (take && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        we         = (state == CAPTURE) && !start && in_valid && (count != DEPTH_C);
        drop       = (state == CAPTURE) && !start && in_valid && (count == DEPTH_C);
        re         = (state == DUMP) && !start && (rd_ptr != count) && (!s1_valid || advance);
        count_next = count;
        if (start) begin
            count_next = '0;
        end else if (we) begin
            count_next = count + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            busy  <= (state_next != IDLE);

            if (start) begin
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end

            if (state == IDLE && state_next == DUMP) begin
                rd_ptr <= '0;
            end else if (re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (state != DUMP || start) begin
                s1_valid  <= 1'b0;
                s1_last   <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (re) begin
                    s1_valid <= 1'b1;
                    s1_last  <= (rd_ptr == count - AW'(1));
                end else if (advance) begin
                    s1_valid <= 1'b0;
                    s1_last  <= 1'b0;
                end
                if (advance) begin
                    out_valid <= 1'b1;
                    out_data  <= ram_rdata;
                    out_last  <= s1_last;
                end else if (take) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

    alu4_trace_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(pack_record(a, b, op, result)),
        .re   (re),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_alu4_trace_recorder.sv
// Bench for alu4_trace_recorder: directed scenarios plus randomized capture
// and dump rounds checked against a queue-based model of the buffer.
module tb_alu4_trace_recorder;
    import alu4_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          dump;
    logic          in_valid;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [2:0]    op;
    logic [3:0]    result;
    logic          out_valid;
    logic          out_ready;
    logic [14:0]   out_data;
    logic          out_last;
    logic [AW-1:0] count;
    logic          full;
    logic          overflow;
    logic          busy;
    state_t        dut_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the stored records in arrival order plus the sticky drop flag.
    logic [14:0] model_q[$];
    bit          model_ovf;

    alu4_trace_recorder #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .dump     (dump),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .state    (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sample(input logic [14:0] r);
        if (model_q.size() < DEPTH) model_q.push_back(r);
        else model_ovf = 1'b1;
    endtask

    task automatic present(input logic [3:0] va, input logic [3:0] vb,
                           input logic [2:0] vop, input logic [3:0] vres);
        a = va; b = vb; op = vop; result = vres;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        model_sample({va, vb, vop, vres});
    endtask

    task automatic present_rand();
        present(4'($urandom), 4'($urandom), 3'($urandom), 4'($urandom));
    endtask

    // The start cycle carries a valid sample that must not be recorded.
    task automatic begin_capture();
        start = 1'b1;
        in_valid = 1'b1;
        a = 4'($urandom); b = 4'($urandom); op = 3'($urandom); result = 4'($urandom);
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic end_capture(input bit with_sample);
        stop = 1'b1;
        if (with_sample) present_rand();
        else tick();
        stop = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, "_overflow"}, 32'(overflow), 32'(model_ovf));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    function automatic bit pick_ready(input int mode, input int j);
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return (j < 5) ? pat[j] : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: always ready, 1: fixed 1,0,0,1,1 pattern, 2: random ready.
    task automatic run_dump(input int mode);
        logic [14:0] exp_q[$];
        logic [14:0] exp_rec;
        logic [14:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        bit          done;
        bit          rdy;
        int          n;
        int          got;
        int          j;
        int          last_cyc;
        exp_q = model_q;
        n = model_q.size();
        got = 0; j = 0; last_cyc = -1;
        done = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        check("dump_busy", 32'(busy), 32'(n != 0));
        if (n == 0) begin
            repeat (4) tick();
            check("empty_dump_valid", 32'(out_valid), 32'd0);
            check("empty_dump_busy", 32'(busy), 32'd0);
            return;
        end
        tick();
        check("latency_e1_valid", 32'(out_valid), 32'd0);
        tick();
        check("latency_e2_valid", 32'(out_valid), 32'd1);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            rdy = pick_ready(mode, j);
            if (out_valid) j++;
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_record", 32'd1, 32'd0);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check("dump_data", 32'(out_data), 32'(exp_rec));
                    check("dump_last", 32'(out_last), 32'(exp_q.size() == 0));
                end
                got++;
                last_cyc = cyc;
                if (out_last) done = 1'b1;
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_last  = out_last;
            tick();
        end
        if (!done) check("dump_timeout", 32'd0, 32'd1);
        check("dump_records", 32'(got), 32'(n));
        check("post_dump_valid", 32'(out_valid), 32'd0);
        check("post_dump_busy", 32'(busy), 32'd0);
        check("post_dump_count", 32'(count), 32'(n));
        if (mode == 0) check("throughput", 32'(last_cyc), 32'(n - 1));
        out_ready = 1'b1;
    endtask

    task automatic wait_first_valid();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; dump = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; op = '0; result = '0; out_ready = 1'b1;
        model_ovf = 1'b0;
        tick();
        tick();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_last", 32'(out_last), 32'd0);
        check("reset_state", 32'(dut_state), 32'(IDLE));
        reset = 1'b1;
        check_status("reset");
        run_dump(0);

        // Directed ALU vectors.
        begin_capture();
        present(4'h3, 4'h5, 3'b000, 4'h8);
        present(4'h9, 4'h2, 3'b001, 4'h7);
        present(4'hF, 4'hF, 3'b010, 4'hF);
        end_capture(1'b0);
        model_q = '{15'b0011_0101_000_1000, 15'b1001_0010_001_0111, 15'b1111_1111_010_1111};
        check_status("directed");
        run_dump(0);
        run_dump(1);
        run_dump(0);

        // Overflow: six samples into four slots keeps the oldest four.
        begin_capture();
        repeat (6) present_rand();
        end_capture(1'b0);
        check_status("overflow");
        run_dump(0);

        // Sample in the stop cycle is kept; in_valid in IDLE is ignored.
        begin_capture();
        repeat (2) present_rand();
        end_capture(1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_status("stop_sample");
        run_dump(1);

        // Reset right after the first transfer of a dump.
        begin_capture();
        repeat (3) present_rand();
        end_capture(1'b0);
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        wait_first_valid();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_reset_valid", 32'(out_valid), 32'd0);
        check("abort_reset_count", 32'(count), 32'd0);
        check("abort_reset_busy", 32'(busy), 32'd0);
        model_q.delete();
        model_ovf = 1'b0;
        run_dump(0);

        // Start mid-dump aborts into a fresh capture.
        begin_capture();
        repeat (3) present_rand();
        end_capture(1'b0);
        dump = 1'b1;
        tick();
        dump = 1'b0;
        wait_first_valid();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd1);
        check("abort_start_state", 32'(dut_state), 32'(CAPTURE));
        check("abort_start_count", 32'(count), 32'd0);
        check("abort_start_valid", 32'(out_valid), 32'd0);
        repeat (2) present_rand();
        end_capture(1'b0);
        check_status("after_abort");
        run_dump(2);

        // Start and dump together: start wins, no output appears.
        start = 1'b1;
        dump = 1'b1;
        tick();
        start = 1'b0;
        dump = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        check("start_dump_state", 32'(dut_state), 32'(CAPTURE));
        repeat (3) tick();
        check("start_dump_valid", 32'(out_valid), 32'd0);
        end_capture(1'b0);
        run_dump(0);

        // Restart inside CAPTURE discards the sample of the restart cycle.
        begin_capture();
        repeat (2) present_rand();
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        present_rand();
        end_capture(1'b0);
        check_status("restart");
        run_dump(0);

        // Randomized rounds.
        for (int it = 0; it < 20; it++) begin
            int n;
            n = $urandom_range(0, 6);
            begin_capture();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                present_rand();
            end
            end_capture(1'($urandom_range(0, 1)));
            check_status("rand");
            run_dump(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
